// File: rtl/sb_serializer_if.sv
// Sideband transmit bundle: parallel message handshake in, serial line and gate enable out.
// Pure wiring; no storage and no added latency.
// Producer holds in_data/in_valid until it sees in_ready; the serial side is never stalled.
interface sb_serializer_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_data;
  logic             out_clk_en;
  logic             out_done;

  // Producer side: offers messages, observes the serial line.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_clk_en,
    input  out_done
  );

  // Serializer side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_clk_en,
    output out_done
  );
endinterface

// File: rtl/sb_serializer.sv
// Sideband serializer: one WIDTH-bit message per handshake, shifted out LSB-first with a gated-clock enable.
// Latency 1: bit 0 is on out_data the cycle after acceptance; one message per WIDTH+GAP+1 cycles.
// in_ready is high only in IDLE; offers during SHIFT/GAP are left pending at the producer.
module sb_serializer #(
  parameter int WIDTH   = 128,
  parameter int WIDTH_W = 8,
  parameter int GAP     = 32,
  parameter int GAP_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sb_serializer_if.slave       sb,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Index of the final bit and final gap cycle; GAP==0 never enters ST_GAP.
  localparam logic [WIDTH_W-1:0] BIT_LAST = WIDTH_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]         state_q,    state_d;
  logic [WIDTH-1:0]   shreg_q,    shreg_d;
  logic [WIDTH_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic               out_data_q, out_data_d;
  logic               clk_en_q,   clk_en_d;
  logic               done_q,     done_d;

  // Next-state logic: line outputs default low so GAP and IDLE drive clk_en=0, data=0.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_data_d = 1'b0;
    clk_en_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sb.in_valid) begin
          out_data_d = sb.in_data[0];
          shreg_d    = sb.in_data >> 1;
          clk_en_d   = 1'b1;
          bit_cnt_d  = '0;
          done_d     = (BIT_LAST == '0);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          // Last bit is on the line this cycle; drop the gate and start the gap.
          gap_cnt_d = '0;
          state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          out_data_d = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          clk_en_d   = 1'b1;
          // out_done is registered, so raise it when launching the final bit.
          done_d     = ((bit_cnt_q + 1'b1) == BIT_LAST);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and line registers; reset drops the gate enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      out_data_q <= 1'b0;
      clk_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      out_data_q <= out_data_d;
      clk_en_q   <= clk_en_d;
      done_q     <= done_d;
    end
  end

  assign sb.in_ready   = (state_q == ST_IDLE);
  assign sb.out_data   = out_data_q;
  assign sb.out_clk_en = clk_en_q;
  assign sb.out_done   = done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_serializer.sv
// Bench for sb_serializer: default 128/32 build plus an 8-bit, zero-gap build.
// Drivers push expected messages into queues; negedge deserializer monitors pop and compare.
// Drivers also check cycle-exact timing of the gate enable, done pulse and handshake.
module tb_sb_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sb_serializer_if #(.WIDTH(128)) m_if ();
  sb_serializer_if #(.WIDTH(8))   s_if ();
  logic m_busy, s_busy;

  sb_serializer #(.WIDTH(128), .WIDTH_W(8), .GAP(32), .GAP_W(6)) u_main (
    .clk(clk), .rst_n(rst_n), .sb(m_if.slave), .busy(m_busy)
  );
  sb_serializer #(.WIDTH(8), .WIDTH_W(3), .GAP(0), .GAP_W(1)) u_small (
    .clk(clk), .rst_n(rst_n), .sb(s_if.slave), .busy(s_busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards and monitor state
  logic [127:0] m_q[$];
  logic [7:0]   s_q[$];
  logic [127:0] m_rx;
  logic [7:0]   s_rx;
  int m_idx = 0, s_idx = 0;
  int m_acc = 0, s_acc = 0;
  int m_got = 0, s_got = 0;
  bit s_after_done = 1'b0;
  int s_low_run = 0;

  // Main monitor: far-end deserializer samples on the falling edge.
  initial begin
    m_rx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_idx = 0;
      end else begin
        if (m_if.in_valid && m_if.in_ready) m_acc++;
        if (m_if.out_clk_en) begin
          if (m_idx < 128) m_rx[m_idx] = m_if.out_data;
          m_idx++;
        end else begin
          check("m_idle_data_low", m_if.out_data, 0);
        end
        if (m_if.out_done) begin
          check("m_done_after_128_bits", m_idx, 128);
          if (m_q.size() == 0) check("m_unexpected_msg", 0, 1);
          else check("m_msg_data", m_rx, m_q.pop_front());
          m_got++;
          m_idx = 0;
        end
      end
    end
  end

  // Small-build monitor, also measures the gated gap between messages.
  initial begin
    s_rx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_idx = 0;
        s_after_done = 1'b0;
      end else begin
        if (s_if.in_valid && s_if.in_ready) s_acc++;
        if (s_if.out_clk_en) begin
          if (s_after_done) begin
            check("s_gap_low_cycles", s_low_run, 1);
            s_after_done = 1'b0;
          end
          if (s_idx < 8) s_rx[s_idx] = s_if.out_data;
          s_idx++;
        end else if (s_after_done) begin
          s_low_run++;
        end
        if (s_if.out_done) begin
          check("s_done_after_8_bits", s_idx, 8);
          if (s_q.size() == 0) check("s_unexpected_msg", 0, 1);
          else check("s_msg_data", {120'd0, s_rx}, {120'd0, s_q.pop_front()});
          s_got++;
          s_idx = 0;
          s_after_done = 1'b1;
          s_low_run = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_main_idle(input string name);
    int n = 0;
    while ((m_busy || m_q.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    check(name, n < 1000, 1);
  endtask

  logic [127:0] b2b[3];
  logic [7:0]   sm[3];
  int acc_cyc[3];
  logic [127:0] msg;
  int acc_before;

  initial begin
    m_if.in_data = '0; m_if.in_valid = 1'b0;
    s_if.in_data = '0; s_if.in_valid = 1'b0;
    b2b[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    b2b[1] = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1234_5678;
    b2b[2] = 128'h8000_0001_FFFF_0000_7E7E_8181_C3C3_3C3D;
    sm[0] = 8'hA5; sm[1] = 8'h3C; sm[2] = 8'h81;

    repeat (3) step();
    rst_n = 1'b1;
    step();
    // Reset state
    check("rst_out_clk_en", m_if.out_clk_en, 0);
    check("rst_out_data", m_if.out_data, 0);
    check("rst_out_done", m_if.out_done, 0);
    check("rst_in_ready", m_if.in_ready, 1);
    check("rst_busy", m_busy, 0);
    check("rst_small_ready", s_if.in_ready, 1);

    // Test 1: reset mid-SHIFT at bit 40
    msg = 128'h1 << 40;
    m_if.in_data = msg; m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    repeat (40) step();
    check("t1_bit40_data", m_if.out_data, 1);
    check("t1_bit40_clk_en", m_if.out_clk_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_clk_en", m_if.out_clk_en, 0);
    check("t1_async_data", m_if.out_data, 0);
    check("t1_async_done", m_if.out_done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("t1_post_ready", m_if.in_ready, 1);
    check("t1_post_busy", m_busy, 0);
    check("t1_post_clk_en", m_if.out_clk_en, 0);

    // Tests 2/3: single message, then the enforced gap
    msg = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    check("t2_ready_before", m_if.in_ready, 1);
    m_if.in_data = msg; m_if.in_valid = 1'b1; m_q.push_back(msg);
    step();
    m_if.in_valid = 1'b0;
    m_if.in_data = '0;
    for (int k = 1; k <= 161; k++) begin
      check($sformatf("t2_clk_en_T+%0d", k), m_if.out_clk_en, (k <= 128));
      check($sformatf("t2_data_T+%0d", k), m_if.out_data, (k == 1 || k == 128));
      check($sformatf("t2_done_T+%0d", k), m_if.out_done, (k == 128));
      check($sformatf("t3_ready_T+%0d", k), m_if.in_ready, (k == 161));
      check($sformatf("t3_busy_T+%0d", k), m_busy, (k <= 160));
      if (k < 161) step();
    end
    check("t2_msg_received", m_got, 1);

    // Test 4: back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      m_if.in_data = b2b[i]; m_if.in_valid = 1'b1; m_q.push_back(b2b[i]);
      while (!m_if.in_ready && n < 400) begin
        step();
        n++;
      end
      check($sformatf("t4_accept_%0d_in_time", i), n < 400, 1);
      acc_cyc[i] = cyc;
      step();
    end
    m_if.in_valid = 1'b0;
    check("t4_spacing_0_1", acc_cyc[1] - acc_cyc[0], 161);
    check("t4_spacing_1_2", acc_cyc[2] - acc_cyc[1], 161);
    wait_main_idle("t4_drain_in_time");
    check("t4_msgs_received", m_got, 4);

    // Test 5: input churn during SHIFT is ignored
    acc_before = m_acc;
    msg = 128'hCAFE_F00D_0BAD_D00D_1357_9BDF_2468_ACE0;
    m_if.in_data = msg; m_if.in_valid = 1'b1; m_q.push_back(msg);
    step();
    for (int j = 0; j < 20; j++) begin
      m_if.in_data = ~msg ^ {96'd0, 32'(j * 32'h0101_0101)};
      m_if.in_valid = j[0];
      step();
    end
    m_if.in_valid = 1'b0;
    wait_main_idle("t5_drain_in_time");
    check("t5_single_accept", m_acc - acc_before, 1);
    check("t5_msgs_received", m_got, 5);

    // Test 6: WIDTH=8, GAP=0 build, continuous traffic
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      s_if.in_data = sm[i]; s_if.in_valid = 1'b1; s_q.push_back(sm[i]);
      while (!s_if.in_ready && n < 100) begin
        step();
        n++;
      end
      check($sformatf("t6_accept_%0d_in_time", i), n < 100, 1);
      acc_cyc[i] = cyc;
      step();
    end
    s_if.in_valid = 1'b0;
    check("t6_period_0_1", acc_cyc[1] - acc_cyc[0], 9);
    check("t6_period_1_2", acc_cyc[2] - acc_cyc[1], 9);
    repeat (15) step();
    check("t6_msgs_received", s_got, 3);
    check("t6_accepts", s_acc, 3);
    check("t6_idle", s_busy, 0);

    check("main_scoreboard_empty", m_q.size(), 0);
    check("small_scoreboard_empty", s_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
